// File: rtl/ex_div_sequencer.sv
// ============================================================================
// Module   : ex_div_sequencer
// Brief    : Multi-cycle radix-2 restoring integer divide/remainder sequencer
//            sitting beside the execute stage. Five-state FSM with a
//            single-cycle fast path for divide-by-zero and signed overflow.
// Options  : EX_DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor|
//            finishes straight from PREP (quotient 0, remainder = dividend).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_sequencer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  start,
  output logic                  ready,
  input  logic                  op_rem,
  input  logic                  is_signed,
  input  logic                  is_word_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [4:0]            dst_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            out_dst_reg,
  output logic                  busy
);

  localparam int DW = DATA_WIDTH;

  // Most-negative values, already in 64-bit extended form
  localparam logic [DW-1:0] MIN_DBL  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MIN_WORD = {{(DW-31){1'b1}}, 31'b0};
  localparam logic [6:0]    CNT_DBL  = 7'd64;
  localparam logic [6:0]    CNT_WORD = 7'd32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [DW-1:0] a_raw, b_raw;
  logic          rem_sel, sgn_op, word_op;
  logic [4:0]    dst_q;

  // Iteration datapath
  logic [DW-1:0] quo_q, rem_q, divs_q;
  logic [6:0]    cnt;
  logic          q_neg, r_neg;

  // Result of a W-variant is always the sign-extended low word
  function automatic logic [DW-1:0] sext_word(input logic [DW-1:0] v);
    return {{(DW-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [DW-1:0] finish_val(input logic [DW-1:0] v, input logic word);
    return word ? sext_word(v) : v;
  endfunction

  // ---------------------------------------------------------------- PREP logic
  logic [DW-1:0] a_ext, b_ext, mag_a, mag_b, special_val;
  logic          a_neg, b_neg, div_zero, overflow, early, take_special;

  assign a_ext = word_op ? (sgn_op ? sext_word(a_raw) : {{(DW-32){1'b0}}, a_raw[31:0]}) : a_raw;
  assign b_ext = word_op ? (sgn_op ? sext_word(b_raw) : {{(DW-32){1'b0}}, b_raw[31:0]}) : b_raw;
  assign a_neg = sgn_op & a_ext[DW-1];
  assign b_neg = sgn_op & b_ext[DW-1];
  assign mag_a = a_neg ? (~a_ext + 1'b1) : a_ext;
  assign mag_b = b_neg ? (~b_ext + 1'b1) : b_ext;

  assign div_zero = (b_ext == '0);
  assign overflow = sgn_op & (b_ext == '1) & (a_ext == (word_op ? MIN_WORD : MIN_DBL));

`ifdef EX_DIV_EARLY_OUT_EN
  assign early = (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  assign take_special = div_zero | overflow | early;

  // Divide-by-zero beats overflow, which beats the early-out shortcut
  always_comb begin
    special_val = '0;
    if (div_zero)      special_val = rem_sel ? a_ext : '1;
    else if (overflow) special_val = rem_sel ? '0 : a_ext;
    else               special_val = rem_sel ? a_ext : '0;
  end

  // ---------------------------------------------------------------- ITER logic
  logic [DW:0]   shifted;
  logic          ge;
  logic [DW-1:0] rem_next, quo_next;

  // remainder stays below the divisor, so the difference always fits in DW bits
  assign shifted  = {rem_q, quo_q[DW-1]};
  assign ge       = (shifted >= {1'b0, divs_q});
  assign rem_next = ge ? (shifted[DW-1:0] - divs_q) : shifted[DW-1:0];
  assign quo_next = {quo_q[DW-2:0], ge};

  // --------------------------------------------------------------- FIXUP logic
  logic [DW-1:0] q_fix, r_fix, fix_val;

  assign q_fix   = q_neg ? (~quo_q + 1'b1) : quo_q;
  assign r_fix   = r_neg ? (~rem_q + 1'b1) : rem_q;
  assign fix_val = finish_val(rem_sel ? r_fix : q_fix, word_op);

  // ---------------------------------------------------------------- handshake
  assign ready     = (state == S_IDLE) & ~flush;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && ready) state_nxt = S_PREP;
      S_PREP:  state_nxt = take_special ? S_DONE : S_ITER;
      S_ITER:  if (cnt == 7'd1) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_raw       <= '0;
      b_raw       <= '0;
      rem_sel     <= 1'b0;
      sgn_op      <= 1'b0;
      word_op     <= 1'b0;
      dst_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      divs_q      <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      result      <= '0;
      out_dst_reg <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_raw   <= dividend;
            b_raw   <= divisor;
            rem_sel <= op_rem;
            sgn_op  <= is_signed;
            word_op <= is_word_op;
            dst_q   <= dst_reg;
          end
        end
        S_PREP: begin
          if (take_special) begin
            result      <= finish_val(special_val, word_op);
            out_dst_reg <= dst_q;
          end else begin
            // word magnitudes start in the top half so 32 shifts consume them
            quo_q  <= word_op ? {mag_a[31:0], 32'b0} : mag_a;
            rem_q  <= '0;
            divs_q <= mag_b;
            cnt    <= word_op ? CNT_WORD : CNT_DBL;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
          end
        end
        S_ITER: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt   <= cnt - 7'd1;
        end
        S_FIXUP: begin
          result      <= fix_val;
          out_dst_reg <= dst_q;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
